alu_lockstep_monitor: RTL and testbench

- Downstream consumer of the dual-ALU lockstep comparator (alu_xor_4).
- Takes both ALU results, both carries and the comparator's x/y flags, and checks them per valid sample.
- Filters transient mismatches, declares a sticky fault after a run of consecutive mismatches, and counts mismatches.
- Captures the first faulting sample and exposes status, count and capture through a Wishbone slave, with an interrupt.

---
 rtl/lockstep_pkg.sv | 30 +++
 rtl/lockstep_wb_regs.sv | 82 ++++++++
 rtl/alu_lockstep_monitor.sv | 167 ++++++++++++++++
 tb/tb_alu_lockstep_monitor.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lockstep_pkg.sv
// Shared definitions for the ALU lockstep monitor: FSM encoding, fault cause
// codes and the register window layout.
package lockstep_pkg;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } state_e;

    // A fault that trips both conditions on the same sample reports 2'b11.
    localparam logic [1:0] CAUSE_THRESH = 2'b01;
    localparam logic [1:0] CAUSE_CMP    = 2'b10;

    localparam logic [3:0] OFF_STATUS  = 4'h0;
    localparam logic [3:0] OFF_COUNT   = 4'h4;
    localparam logic [3:0] OFF_CAPTURE = 4'h8;
    localparam logic [3:0] OFF_CTRL    = 4'hC;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_IRQ_BIT = 1;
    localparam int CTRL_CLR_BIT = 2;

    localparam int CAP_W = 12;

    function automatic logic [1:0] cause_code(input logic thr_hit, input logic cmp_err);
        return (thr_hit ? CAUSE_THRESH : 2'b00) | (cmp_err ? CAUSE_CMP : 2'b00);
    endfunction

endpackage

// File: rtl/lockstep_wb_regs.sv
// Wishbone classic slave for the lockstep monitor: address decode, single-cycle
// ack, CTRL register with self-clearing clear strobe, and registered read mux.
module lockstep_wb_regs
    import lockstep_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [31:0] i_status,
    input  logic [31:0] i_count,
    input  logic [31:0] i_capture,
    output logic        o_enable,
    output logic        o_irq_en,
    output logic        o_clear
);

    logic        r_ack;
    logic [31:0] r_dat;
    logic        r_enable;
    logic        r_irq_en;

    logic        w_req;
    logic        w_hit;
    logic [3:0]  w_off;
    logic        w_ctrl_wr;
    logic [31:0] w_rdata;
    logic        w_unused;

    // A new request is only taken while ack is low, so a held strobe is
    // answered every other cycle.
    assign w_req     = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_hit     = (wbs_adr_i[31:4] == ADDR_BASE[31:4]) & (wbs_adr_i[1:0] == 2'b00);
    assign w_off     = {wbs_adr_i[3:2], 2'b00};
    assign w_ctrl_wr = w_req & wbs_we_i & w_hit & (w_off == OFF_CTRL) & wbs_sel_i[0];
    assign o_clear   = w_ctrl_wr & wbs_dat_i[CTRL_CLR_BIT];

    assign w_unused  = &{1'b0, wbs_sel_i[3:1], wbs_dat_i[31:3]};

    always_comb begin
        w_rdata = 32'd0;
        if (w_hit) begin
            case (w_off)
                OFF_STATUS:  w_rdata = i_status;
                OFF_COUNT:   w_rdata = i_count;
                OFF_CAPTURE: w_rdata = i_capture;
                OFF_CTRL:    w_rdata = {30'd0, r_irq_en, r_enable};
                default:     w_rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_ack    <= 1'b0;
            r_dat    <= 32'd0;
            r_enable <= 1'b1;
            r_irq_en <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req & ~wbs_we_i) ? w_rdata : 32'd0;
            if (w_ctrl_wr) begin
                r_enable <= wbs_dat_i[CTRL_EN_BIT];
                r_irq_en <= wbs_dat_i[CTRL_IRQ_BIT];
            end
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign o_enable  = r_enable;
    assign o_irq_en  = r_irq_en;

endmodule

// File: rtl/alu_lockstep_monitor.sv
// Lockstep ALU monitor: registers comparator samples, filters transient
// mismatches through an OK/SUSPECT/FAULT FSM, counts mismatches, captures the first fault.
module alu_lockstep_monitor
    import lockstep_pkg::*;
#(
    parameter int          CNT_W     = 16,
    parameter int          THRESH    = 3,
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        in_valid,
    input  logic [3:0]  alu_out1,
    input  logic [3:0]  alu_out2,
    input  logic        carry1,
    input  logic        carry2,
    input  logic [3:0]  cmp_x,
    input  logic        cmp_y,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        fault_o,
    output logic        fault_irq
);

    localparam logic [3:0] THRESH_RUN = 4'(THRESH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             r_s_valid_p1;
    logic [3:0]       r_out1_p1;
    logic [3:0]       r_out2_p1;
    logic             r_c1_p1;
    logic             r_c2_p1;
    logic [3:0]       r_x_p1;
    logic             r_y_p1;

    state_e           r_state;
    logic [3:0]       r_run;
    logic [CNT_W-1:0] r_count;
    logic [CAP_W-1:0] r_capture;

    state_e           w_state_nx;
    logic [3:0]       w_run_nx;
    logic [CNT_W-1:0] w_count_nx;
    logic [CAP_W-1:0] w_capture_nx;
    logic [3:0]       w_run_inc;
    logic             w_thr_hit;

    logic             w_enable;
    logic             w_irq_en;
    logic             w_clear;
    logic             w_miss;
    logic             w_cmp_err;
    logic             w_step;
    logic [31:0]      w_status;
    logic [31:0]      w_count32;
    logic [31:0]      w_capture32;

    // ---- stage 1: sample capture ----
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_s_valid_p1 <= 1'b0;
        end else begin
            r_s_valid_p1 <= in_valid & w_enable;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (in_valid & w_enable) begin
            r_out1_p1 <= alu_out1;
            r_out2_p1 <= alu_out2;
            r_c1_p1   <= carry1;
            r_c2_p1   <= carry2;
            r_x_p1    <= cmp_x;
            r_y_p1    <= cmp_y;
        end
    end

    assign w_miss    = (r_out1_p1 != r_out2_p1) | (r_c1_p1 ^ r_c2_p1);
    assign w_cmp_err = (r_x_p1 != (r_out1_p1 ^ r_out2_p1)) | (r_y_p1 != (r_c1_p1 ^ r_c2_p1));
    // A clear landing on the same edge as a sample discards that sample.
    assign w_step    = r_s_valid_p1 & w_enable & ~w_clear;

    // ---- stage 2: classification FSM, counter, capture ----
    always_comb begin
        w_state_nx   = r_state;
        w_run_nx     = r_run;
        w_count_nx   = r_count;
        w_capture_nx = r_capture;
        w_run_inc    = (r_state == ST_OK) ? 4'd1 : r_run + 4'd1;
        w_thr_hit    = w_miss & (w_run_inc >= THRESH_RUN);

        if (w_clear) begin
            w_state_nx = ST_OK;
            w_run_nx   = 4'd0;
        end else if (w_step) begin
            if (w_miss) begin
                w_count_nx = sat_inc(r_count);
            end
            if (r_state != ST_FAULT) begin
                if (w_cmp_err | w_thr_hit) begin
                    w_state_nx   = ST_FAULT;
                    w_run_nx     = w_miss ? w_run_inc : r_run;
                    w_capture_nx = {cause_code(w_thr_hit, w_cmp_err),
                                    r_out1_p1, r_out2_p1, r_c1_p1, r_c2_p1};
                end else if (w_miss) begin
                    w_state_nx = ST_SUSPECT;
                    w_run_nx   = w_run_inc;
                end else begin
                    w_state_nx = ST_OK;
                    w_run_nx   = 4'd0;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state   <= ST_OK;
            r_run     <= 4'd0;
            r_count   <= '0;
            r_capture <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_run     <= w_run_nx;
            r_count   <= w_count_nx;
            r_capture <= w_capture_nx;
        end
    end

    assign fault_o   = (r_state == ST_FAULT);
    assign fault_irq = fault_o & w_irq_en;

    assign w_status    = {26'd0, r_run, r_state};
    assign w_count32   = 32'(r_count);
    assign w_capture32 = {{(32-CAP_W){1'b0}}, r_capture};

    lockstep_wb_regs #(
        .ADDR_BASE (ADDR_BASE)
    ) u_regs (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_n  (wb_rst_n),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .i_status  (w_status),
        .i_count   (w_count32),
        .i_capture (w_capture32),
        .o_enable  (w_enable),
        .o_irq_en  (w_irq_en),
        .o_clear   (w_clear)
    );

endmodule

// File: tb/tb_alu_lockstep_monitor.sv
// Directed bench for alu_lockstep_monitor: a table of samples with expected
// fault/status/count, then hand sequences for clear, enable, saturation and reset.
module tb_alu_lockstep_monitor;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        wb_clk_i;
    logic        wb_rst_n;
    logic        in_valid;
    logic [3:0]  alu_out1;
    logic [3:0]  alu_out2;
    logic        carry1;
    logic        carry2;
    logic [3:0]  cmp_x;
    logic        cmp_y;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        fault_o;
    logic        fault_irq;

    alu_lockstep_monitor #(
        .CNT_W     (4),
        .THRESH    (3),
        .ADDR_BASE (BASE)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_n  (wb_rst_n),
        .in_valid  (in_valid),
        .alu_out1  (alu_out1),
        .alu_out2  (alu_out2),
        .carry1    (carry1),
        .carry2    (carry2),
        .cmp_x     (cmp_x),
        .cmp_y     (cmp_y),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .fault_o   (fault_o),
        .fault_irq (fault_irq)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic       pre_rst;
        logic [3:0] o1;
        logic [3:0] o2;
        logic       c1;
        logic       c2;
        logic [3:0] x;
        logic       y;
        logic       exp_fault;
        logic [3:0] exp_run;
        logic [1:0] exp_state;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t tbl [19];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic pr, input logic [3:0] o1, input logic [3:0] o2,
                                input logic c1, input logic c2, input logic [3:0] x, input logic y,
                                input logic ef, input logic [3:0] er, input logic [1:0] es,
                                input logic [3:0] ec);
        vec_t v;
        v.pre_rst = pr; v.o1 = o1; v.o2 = o2; v.c1 = c1; v.c2 = c2; v.x = x; v.y = y;
        v.exp_fault = ef; v.exp_run = er; v.exp_state = es; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           output logic [31:0] rd, output int lat);
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = 4'hF;
        lat = 0;
        rd  = 32'd0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o) begin
                lat = i;
                rd  = wbs_dat_o;
                break;
            end
        end
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        if (lat == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL wb_timeout: adr 0x%0h got no ack, expected ack within 8 cycles", adr);
        end
    endtask

    task automatic rd_chk(input string name, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] d;
        int          l;
        wb_xfer(1'b0, BASE + 32'(off), 32'd0, d, l);
        chk(name, d, exp);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] dat);
        logic [31:0] d;
        int          l;
        wb_xfer(1'b1, BASE + 32'(off), dat, d, l);
    endtask

    task automatic send(input logic [3:0] o1, input logic [3:0] o2, input logic c1,
                        input logic c2, input logic [3:0] x, input logic y);
        @(negedge wb_clk_i);
        alu_out1 = o1; alu_out2 = o2; carry1 = c1; carry2 = c2; cmp_x = x; cmp_y = y;
        in_valid = 1'b1;
        @(negedge wb_clk_i);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge wb_clk_i);
        wb_rst_n = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected $finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] cap1;
        logic [11:0] cap2;
        logic [31:0] d;
        int          l;
        int          acks;

        wb_rst_n = 1'b0; in_valid = 1'b0;
        alu_out1 = '0; alu_out2 = '0; carry1 = 1'b0; carry2 = 1'b0; cmp_x = '0; cmp_y = 1'b0;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
        wbs_adr_i = '0; wbs_dat_i = '0;

        for (int i = 0; i < 10; i++) tbl[i] = mk(0, 4'hA, 4'hA, 0, 0, 4'h0, 0, 0, 4'd0, 2'd0, 4'd0);
        tbl[10] = mk(0, 4'h5, 4'h4, 0, 0, 4'h1, 0, 0, 4'd1, 2'd1, 4'd1);
        tbl[11] = mk(0, 4'h5, 4'h4, 0, 0, 4'h1, 0, 0, 4'd2, 2'd1, 4'd2);
        tbl[12] = mk(0, 4'hA, 4'hA, 0, 0, 4'h0, 0, 0, 4'd0, 2'd0, 4'd2);
        tbl[13] = mk(0, 4'h5, 4'h4, 0, 0, 4'h1, 0, 0, 4'd1, 2'd1, 4'd3);
        tbl[14] = mk(0, 4'h6, 4'h6, 1, 0, 4'h0, 1, 0, 4'd2, 2'd1, 4'd4);
        tbl[15] = mk(0, 4'hA, 4'hA, 1, 1, 4'h0, 0, 0, 4'd0, 2'd0, 4'd4);
        tbl[16] = mk(1, 4'h9, 4'h8, 0, 0, 4'h1, 0, 0, 4'd1, 2'd1, 4'd1);
        tbl[17] = mk(0, 4'h9, 4'h8, 0, 0, 4'h1, 0, 0, 4'd2, 2'd1, 4'd2);
        tbl[18] = mk(0, 4'h9, 4'h8, 0, 0, 4'h1, 0, 1, 4'd3, 2'd2, 4'd3);

        // Reset values, observed both during and after reset.
        repeat (3) @(negedge wb_clk_i);
        chk("rst fault_o", 32'(fault_o), 32'd0);
        chk("rst fault_irq", 32'(fault_irq), 32'd0);
        chk("rst ack", 32'(wbs_ack_o), 32'd0);
        chk("rst dat_o", wbs_dat_o, 32'd0);
        wb_rst_n = 1'b1;
        rd_chk("rst STATUS", 4'h0, 32'd0);
        rd_chk("rst COUNT", 4'h4, 32'd0);
        rd_chk("rst CAPTURE", 4'h8, 32'd0);
        rd_chk("rst CTRL", 4'hC, 32'd1);

        for (int i = 0; i < 19; i++) begin
            if (tbl[i].pre_rst) do_reset();
            send(tbl[i].o1, tbl[i].o2, tbl[i].c1, tbl[i].c2, tbl[i].x, tbl[i].y);
            @(negedge wb_clk_i);
            chk($sformatf("vec%0d fault_o", i), 32'(fault_o), 32'(tbl[i].exp_fault));
            rd_chk($sformatf("vec%0d STATUS", i), 4'h0, 32'({tbl[i].exp_run, tbl[i].exp_state}));
            rd_chk($sformatf("vec%0d COUNT", i), 4'h4, 32'(tbl[i].exp_cnt));
        end

        // Threshold fault capture, then a later mismatch must not overwrite it.
        cap1 = {2'b01, 4'h9, 4'h8, 1'b0, 1'b0};
        rd_chk("thr CAPTURE", 4'h8, 32'(cap1));
        send(4'h3, 4'h8, 0, 0, 4'hB, 0);
        @(negedge wb_clk_i);
        chk("sticky fault_o", 32'(fault_o), 32'd1);
        rd_chk("sticky CAPTURE", 4'h8, 32'(cap1));
        rd_chk("sticky COUNT", 4'h4, 32'd4);
        rd_chk("sticky STATUS", 4'h0, 32'({4'd3, 2'd2}));

        // Comparator defect: matching ALUs, wrong cmp_x.
        do_reset();
        wr(4'hC, 32'h3);
        send(4'hA, 4'hA, 0, 0, 4'h2, 0);
        @(negedge wb_clk_i);
        chk("cmp fault_o", 32'(fault_o), 32'd1);
        chk("cmp fault_irq", 32'(fault_irq), 32'd1);
        cap2 = {2'b10, 4'hA, 4'hA, 1'b0, 1'b0};
        rd_chk("cmp CAPTURE", 4'h8, 32'(cap2));
        rd_chk("cmp COUNT", 4'h4, 32'd0);
        wr(4'hC, 32'h7);
        chk("clr fault_o", 32'(fault_o), 32'd0);
        chk("clr fault_irq", 32'(fault_irq), 32'd0);
        rd_chk("clr STATUS", 4'h0, 32'd0);
        rd_chk("clr CTRL", 4'hC, 32'd3);

        // Clear write coinciding with a mismatch reaching stage 2.
        send(4'h5, 4'h4, 0, 0, 4'h1, 0);
        @(negedge wb_clk_i);
        rd_chk("pre-race STATUS", 4'h0, 32'({4'd1, 2'd1}));
        @(negedge wb_clk_i);
        alu_out1 = 4'h5; alu_out2 = 4'h4; carry1 = 0; carry2 = 0; cmp_x = 4'h1; cmp_y = 0;
        in_valid = 1'b1;
        @(negedge wb_clk_i);
        in_valid  = 1'b0;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
        wbs_adr_i = BASE + 32'hC; wbs_dat_i = 32'h7;
        @(posedge wb_clk_i);
        #1;
        chk("race ack", 32'(wbs_ack_o), 32'd1);
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        rd_chk("race STATUS", 4'h0, 32'd0);
        rd_chk("race COUNT", 4'h4, 32'd1);

        // Monitoring disabled: mismatches are ignored.
        wr(4'hC, 32'h2);
        for (int i = 0; i < 5; i++) send(4'h7, 4'h1, 0, 0, 4'h6, 0);
        @(negedge wb_clk_i);
        rd_chk("dis COUNT", 4'h4, 32'd1);
        rd_chk("dis STATUS", 4'h0, 32'd0);
        rd_chk("dis CTRL", 4'hC, 32'd2);
        wr(4'hC, 32'h1);

        // Saturation of the 4-bit counter.
        do_reset();
        for (int i = 0; i < 20; i++) send(4'h9, 4'h8, 0, 0, 4'h1, 0);
        @(negedge wb_clk_i);
        rd_chk("sat COUNT", 4'h4, 32'd15);
        chk("sat fault_o", 32'(fault_o), 32'd1);

        // Unmapped read, RO write, back-to-back strobe.
        wb_xfer(1'b0, BASE + 32'h10, 32'd0, d, l);
        chk("unmapped latency", 32'(l), 32'd1);
        chk("unmapped data", d, 32'd0);
        wr(4'h0, 32'hFFFF_FFFF);
        rd_chk("ro STATUS", 4'h0, 32'({4'd3, 2'd2}));
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE + 32'h4;
        acks = 0;
        repeat (4) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o) acks++;
        end
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        chk("b2b acks", 32'(acks), 32'd2);

        // Asynchronous reset while an ack is on the bus.
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE + 32'h4;
        @(posedge wb_clk_i);
        #1;
        chk("pre-rst ack", 32'(wbs_ack_o), 32'd1);
        chk("pre-rst data", wbs_dat_o, 32'd15);
        #1;
        wb_rst_n = 1'b0;
        #1;
        chk("mid-rst ack", 32'(wbs_ack_o), 32'd0);
        chk("mid-rst dat_o", wbs_dat_o, 32'd0);
        chk("mid-rst fault_o", 32'(fault_o), 32'd0);
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        rd_chk("post-rst STATUS", 4'h0, 32'd0);
        rd_chk("post-rst COUNT", 4'h4, 32'd0);
        rd_chk("post-rst CAPTURE", 4'h8, 32'd0);
        rd_chk("post-rst CTRL", 4'hC, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
